// File: rtl/pipeif_fetch.sv
// Instruction-fetch stage: PC, next-PC select, req/ack imem fetch and IF/ID register.
// Optional bubble counter port/logic enabled by defining IF_BUBBLE_CNT_EN.
//
// state  | meaning
// S_REQ  | request outstanding at imem_addr = pc, waiting for imem_ack
// S_HOLD | fetched word parked in ibuf while ID is stalled, no request
module pipeif_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] ra,
  input  logic [31:0] jpc,
  input  logic        nostall,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] inst
`ifdef IF_BUBBLE_CNT_EN
  ,
  output logic [31:0] bubble_cnt
`endif
);

  typedef enum logic {S_REQ = 1'b0, S_HOLD = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic [31:0] ibuf;
  logic        ready;
  logic [31:0] ready_inst;
  logic [31:0] pc4;
  logic [31:0] target;
  logic [31:0] npc_raw;
  logic [31:0] npc;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= S_REQ;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:   if (imem_ack && !nostall) state_nxt = S_HOLD;
      S_HOLD:  if (nostall)              state_nxt = S_REQ;
      default: state_nxt = S_REQ;
    endcase
  end

  always_comb begin
    imem_req  = (state == S_REQ);
    imem_addr = pc;
  end

  // An ack only counts while a request is outstanding.
  assign ready      = (state == S_HOLD) || imem_ack;
  assign ready_inst = (state == S_HOLD) ? ibuf : imem_rdata;
  assign pc4        = pc + 32'd4;

  always_comb begin
    target = pc4;
    case (pcsource)
      2'b01:   target = bpc;
      2'b10:   target = ra;
      2'b11:   target = jpc;
      default: target = pc4;
    endcase
  end

  // A live redirect from ID beats one parked while the delay slot was in flight.
  assign npc_raw = (pcsource != 2'b00) ? target : (redir_valid ? redir_pc : pc4);
  assign npc     = {npc_raw[31:2], 2'b00};

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pc          <= RESET_PC;
      dpc4        <= 32'd0;
      inst        <= NOP_INST;
      redir_valid <= 1'b0;
      redir_pc    <= 32'd0;
      ibuf        <= 32'd0;
    end else begin
      if (state == S_REQ && imem_ack && !nostall)
        ibuf <= imem_rdata;
      if (nostall) begin
        if (ready) begin
          inst        <= ready_inst;
          dpc4        <= pc4;
          pc          <= npc;
          redir_valid <= 1'b0;
        end else begin
          inst <= NOP_INST;
          if (pcsource != 2'b00) begin
            redir_pc    <= {target[31:2], 2'b00};
            redir_valid <= 1'b1;
          end
        end
      end
    end
  end

`ifdef IF_BUBBLE_CNT_EN
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)                 bubble_cnt <= 32'd0;
    else if (nostall && !ready) bubble_cnt <= bubble_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pipeif_fetch.sv
// Directed table-driven bench for pipeif_fetch plus a hand-written reset-mid-fetch sequence.
module tb_pipeif_fetch;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        clrn;
  logic [1:0]  pcsource;
  logic [31:0] bpc, ra, jpc;
  logic        nostall;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr, pc, dpc4, inst;
`ifdef IF_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
  int          exp_bub = 0;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0]  ps;
    logic [31:0] bpc, ra, jpc;
    logic        ns, ack;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr, pc, inst, dpc4;
    logic        bub;
  } vec_t;

  vec_t vq[$];

  pipeif_fetch dut (
    .clk(clk), .clrn(clrn), .pcsource(pcsource), .bpc(bpc), .ra(ra), .jpc(jpc),
    .nostall(nostall), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc), .dpc4(dpc4), .inst(inst)
`ifdef IF_BUBBLE_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] ps, input logic [31:0] b, input logic [31:0] r,
                     input logic [31:0] j, input logic ns, input logic ack,
                     input logic [31:0] rd, input logic req, input logic [31:0] addr,
                     input logic [31:0] epc, input logic [31:0] einst,
                     input logic [31:0] edpc4, input logic bub);
    vec_t v;
    v.ps = ps; v.bpc = b; v.ra = r; v.jpc = j; v.ns = ns; v.ack = ack; v.rdata = rd;
    v.req = req; v.addr = addr; v.pc = epc; v.inst = einst; v.dpc4 = edpc4; v.bub = bub;
    vq.push_back(v);
  endtask

  // Plain sequential fetch: ack at addr a with word a|0x1000, no stall.
  task automatic f(input logic [31:0] a);
    add(2'b00, 0, 0, 0, 1'b1, 1'b1, a | 32'h1000, 1'b1, a, a + 32'd4, a | 32'h1000, a + 32'd4, 1'b0);
  endtask

  task automatic drive(input logic [1:0] ps, input logic [31:0] b, input logic [31:0] r,
                       input logic [31:0] j, input logic ns, input logic ack,
                       input logic [31:0] rd);
    pcsource = ps; bpc = b; ra = r; jpc = j; nostall = ns; imem_ack = ack; imem_rdata = rd;
  endtask

  initial begin
    clrn = 1'b0;
    drive(2'b00, 0, 0, 0, 1'b1, 1'b0, 0);

    for (logic [31:0] a = 0; a < 32'h10; a += 4) f(a);
    repeat (3) add(2'b00, 0, 0, 0, 1'b1, 1'b0, 0, 1'b1, 32'h10, 32'h10, NOP, 32'h10, 1'b1);
    for (logic [31:0] a = 32'h10; a < 32'h20; a += 4) f(a);
    add(2'b00, 0, 0, 0, 1'b0, 1'b1, 32'h1020,     1'b1, 32'h20, 32'h20, 32'h101C, 32'h20, 1'b0);
    add(2'b00, 0, 0, 0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h20, 32'h20, 32'h101C, 32'h20, 1'b0);
    add(2'b00, 0, 0, 0, 1'b1, 1'b0, 0,            1'b0, 32'h20, 32'h24, 32'h1020, 32'h24, 1'b0);
    for (logic [31:0] a = 32'h24; a < 32'h40; a += 4) f(a);
    add(2'b01, 32'h100, 0, 0, 1'b1, 1'b0, 0,        1'b1, 32'h40, 32'h40,  NOP,      32'h40, 1'b1);
    add(2'b00, 0, 0, 0,       1'b1, 1'b1, 32'h1040, 1'b1, 32'h40, 32'h100, 32'h1040, 32'h44, 1'b0);
    f(32'h100);
    add(2'b01, 32'h200, 0, 0, 1'b1, 1'b0, 0,        1'b1, 32'h104, 32'h104, NOP,      32'h104, 1'b1);
    add(2'b11, 0, 0, 32'h300, 1'b1, 1'b0, 0,        1'b1, 32'h104, 32'h104, NOP,      32'h104, 1'b1);
    add(2'b00, 0, 0, 0,       1'b1, 1'b1, 32'h1104, 1'b1, 32'h104, 32'h300, 32'h1104, 32'h108, 1'b0);
    add(2'b11, 0, 0, 32'h2000, 1'b1, 1'b1, 32'h1300, 1'b1, 32'h300, 32'h2000, 32'h1300, 32'h304, 1'b0);
    add(2'b10, 0, 32'h3003, 0, 1'b1, 1'b1, 32'h3000, 1'b1, 32'h2000, 32'h3000, 32'h3000, 32'h2004, 1'b0);
    f(32'h3000);
    add(2'b01, 32'h400, 0, 0, 1'b1, 1'b0, 0,        1'b1, 32'h3004, 32'h3004, NOP,     32'h3004, 1'b1);
    add(2'b11, 0, 0, 32'h500, 1'b1, 1'b1, 32'h5555, 1'b1, 32'h3004, 32'h500,  32'h5555, 32'h3008, 1'b0);
    f(32'h500);
    add(2'b11, 0, 0, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h6666, 1'b1, 32'h504, 32'hFFFF_FFFC, 32'h6666, 32'h508, 1'b0);
    add(2'b00, 0, 0, 0, 1'b1, 1'b1, 32'h7777, 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h7777, 32'h0, 1'b0);
    add(2'b00, 0, 0, 0,       1'b0, 1'b0, 0, 1'b1, 32'h0, 32'h0, 32'h7777, 32'h0, 1'b0);
    add(2'b01, 32'h900, 0, 0, 1'b0, 1'b0, 0, 1'b1, 32'h0, 32'h0, 32'h7777, 32'h0, 1'b0);
    f(32'h0);

    repeat (2) @(negedge clk);
    #1;
    check("reset_pc", pc, 32'h0);
    check("reset_inst", inst, NOP);
    check("reset_dpc4", dpc4, 32'h0);
`ifdef IF_BUBBLE_CNT_EN
    check("reset_bubble_cnt", bubble_cnt, 32'h0);
`endif
    @(negedge clk);
    clrn = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].ps, vq[i].bpc, vq[i].ra, vq[i].jpc, vq[i].ns, vq[i].ack, vq[i].rdata);
      #1;
      check($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vq[i].req});
      check($sformatf("v%0d_addr", i), imem_addr, vq[i].addr);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_pc", i), pc, vq[i].pc);
      check($sformatf("v%0d_inst", i), inst, vq[i].inst);
      check($sformatf("v%0d_dpc4", i), dpc4, vq[i].dpc4);
`ifdef IF_BUBBLE_CNT_EN
      if (vq[i].bub) exp_bub++;
      check($sformatf("v%0d_bubble_cnt", i), bubble_cnt, exp_bub);
`endif
      @(negedge clk);
    end

    // Reset mid-request at pc=0x80 with a redirect pending.
    drive(2'b11, 0, 0, 32'h80, 1'b1, 1'b1, 32'h1234);
    @(posedge clk); #1;
    check("mr_pc_80", pc, 32'h80);
    @(negedge clk);
    drive(2'b01, 32'h700, 0, 0, 1'b1, 1'b0, 0);
    @(posedge clk); #1;
    check("mr_pc_hold", pc, 32'h80);
    check("mr_inst_nop", inst, NOP);
    @(negedge clk);
    drive(2'b00, 0, 0, 0, 1'b1, 1'b0, 0);
    clrn = 1'b0;
    #1;
    check("mr_rst_pc", pc, 32'h0);
    check("mr_rst_inst", inst, NOP);
    check("mr_rst_dpc4", dpc4, 32'h0);
    @(negedge clk);
    clrn = 1'b1;
    #1;
    check("mr_req", {31'd0, imem_req}, 32'd1);
    check("mr_addr", imem_addr, 32'h0);
    drive(2'b00, 0, 0, 0, 1'b1, 1'b1, 32'h1000);
    @(posedge clk); #1;
    check("mr_pc_after", pc, 32'h4);
    check("mr_inst_after", inst, 32'h1000);
    check("mr_dpc4_after", dpc4, 32'h4);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
